// File: rtl/signal_monitor.sv
// Safety supervisor for the traffic/pedestrian light controller: flags lamp conflicts, bad codes, bad steps and stuck states.
// Outputs are registered, so a violation sampled at edge N is visible right after edge N.
module signal_monitor #(
  parameter int MAX_DWELL   = 15,
  parameter int ARM_CYCLES  = 2,
  parameter int REL_TIMEOUT = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       estado,
  input  logic [4:0]       saida,
  input  logic             maint,
  input  logic             clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(REL_TIMEOUT + 1);

  localparam logic [2:0] EST1  = 3'b000;
  localparam logic [2:0] EST2  = 3'b100;
  localparam logic [2:0] EST3  = 3'b001;
  localparam logic [2:0] EST4  = 3'b101;
  localparam logic [2:0] INDEF = 3'b010;

  typedef enum logic [1:0] {ARM, RUN, FAULT, RELEASE} state_t;

  state_t          state;
  logic [AW-1:0]   arm_cnt;
  logic [DW-1:0]   dwell;
  logic [TW-1:0]   rel_tmr;
  logic [2:0]      prev_estado;

  logic            code_ok;
  logic            step_ok;
  logic [DW-1:0]   dwell_next;
  logic [2:0]      run_code;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    code_ok = (estado inside {EST1, EST2, EST3, EST4, INDEF});
    // Entry into INDEF is never a legal step while running, so it is simply absent here.
    step_ok = (estado == prev_estado)
            || (prev_estado == EST1 && estado == EST2)
            || (prev_estado == EST2 && estado == EST3)
            || (prev_estado == EST3 && estado == EST4)
            || (prev_estado == EST4 && estado == EST1);

    dwell_next = '0;
    if (estado == prev_estado)
      dwell_next = (dwell == DW'(MAX_DWELL)) ? dwell : dwell + 1'b1;

    run_code = 3'd0;
    if (saida[2] & saida[0])          run_code = 3'd1;
    else if (saida[4] & saida[2])     run_code = 3'd2;
    else if (!code_ok)                run_code = 3'd3;
    else if (!step_ok)                run_code = 3'd4;
    else if (dwell_next == DW'(MAX_DWELL)) run_code = 3'd5;
    else if (maint)                   run_code = 3'd7;

    cnt_inc = (fault_cnt == '1) ? fault_cnt : fault_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARM;
      arm_cnt     <= '0;
      dwell       <= '0;
      rel_tmr     <= '0;
      prev_estado <= EST1;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_cnt   <= '0;
    end else begin
      prev_estado <= estado;
      unique case (state)
        ARM: begin
          dwell <= dwell_next;
          if (arm_cnt == AW'(ARM_CYCLES - 1)) state <= RUN;
          else arm_cnt <= arm_cnt + 1'b1;
        end
        RUN: begin
          dwell <= dwell_next;
          if (run_code != 3'd0) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= run_code;
            fault_cnt  <= cnt_inc;
          end
        end
        FAULT: begin
          dwell <= '0;
          if (clr && !maint) begin
            state   <= RELEASE;
            fault   <= 1'b0;
            rel_tmr <= '0;
          end
        end
        RELEASE: begin
          dwell <= '0;
          if (!code_ok) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 3'd3;
            fault_cnt  <= cnt_inc;
          end else if (estado == EST1) begin
            state      <= RUN;
            fault_code <= 3'd0;
          end else if (rel_tmr == TW'(REL_TIMEOUT - 1)) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 3'd6;
            fault_cnt  <= cnt_inc;
          end else begin
            rel_tmr <= rel_tmr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
